mux_2_1: RTL and testbench
==========================

Name: mux_2_1

Overview:
- Parameterised-width 2:1 data multiplexer: selects one of two w-bit words, `dA` or `dB`, under `sel`.
- Provides a combinational output `muxOUT` and a one-cycle registered copy `muxOUT_q` for timing-closed downstream consumers.
- Leaf datapath block used wherever a two-source word select is needed.
- The clock and reset serve only the registered copy; the combinational path ignores them.

Parameters:
- w, default 4, data word width in bits (w >= 1). All data ports are indexed [w:1].

Ports:
- clk  input  1  system clock; `muxOUT_q` updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset; clears `muxOUT_q`.
- dA  input  w [w:1]  data source A, selected when `sel` = 0.
- dB  input  w [w:1]  data source B, selected when `sel` = 1.
- sel  input  1  select: 0 -> `dA`, 1 -> `dB`.
- muxOUT  output  w [w:1]  combinational mux result.
- muxOUT_q  output  w [w:1]  registered mux result.

Interface decision: one clock (`clk`); reset `rst_n` is asynchronous and active-low.

Behaviour:
- muxOUT:
  - `muxOUT` = `sel` ? `dB` : `dA`, purely combinational, zero latency.
  - Follows any input change within the same delta/timestep.
  - No dependence on `clk` or `rst_n`; valid during reset.
- Full width is passed through; no bit truncation, extension or reordering. Bit i of the output comes from bit i of the selected input, i = 1..w.
- Non-0/1 `sel` (X/Z) in simulation: output is X on bits where `dA` and `dB` differ and equal the common value where they agree (standard ternary semantics). Synthesis treats `sel` as a clean 0/1.
- muxOUT_q:
  - On `rst_n` falling, or while `rst_n` = 0: `muxOUT_q` = 0 immediately, independent of `clk`.
  - On each `clk` rising edge with `rst_n` = 1: `muxOUT_q` <= current `muxOUT`. Latency is 1 cycle.
  - Reset deassertion is not synchronised internally; the integrator guarantees release away from a `clk` edge.
  - Reset asserted mid-operation: `muxOUT_q` clears at once. The first capture after release occurs on the next rising `clk` edge.
  - Inputs changing between edges affect `muxOUT` only. `muxOUT_q` samples only at the edge.
- Reset values: `muxOUT_q` = {w{1'b0}}. `muxOUT` has no reset value; it is a function of its inputs.
- No state machine and no handshake.

Decomposition:
- No shared package required; no typedefs or constants beyond parameter w.
- Single module, no sub-modules.
- The combinational select and the output register live in the same module.

Test Plan:
- w=4, `rst_n`=1, `dA`=4'h0, `dB`=4'h1; toggle `sel` 0,1,0,1 every 10 ns -> `muxOUT` = 0,1,0,1 immediately after each change.
- `dA`=4'hA, `dB`=4'h5, `sel`=0 then 1 -> `muxOUT` = 4'hA then 4'h5. Check all bits independently, with no cross-bit leakage.
- Registered path: `sel` changes 0->1 between edges with `dA`=3, `dB`=C -> `muxOUT_q` = 3 until the next rising `clk`, then C.
- Async reset: hold `muxOUT_q`=C, drive `rst_n`=0 mid-cycle -> `muxOUT_q`=0 with no clock edge, while `muxOUT` still equals the selected input. Release `rst_n` -> capture resumes at the next rising edge.
- Parameter sweep w=1 and w=16: `dA`=all-ones, `dB`=0, toggle `sel` -> `muxOUT` = all-ones / 0 at full width, and `muxOUT_q` follows one cycle later.
- Inputs change while `sel` is held constant (`sel`=1, `dB` 0->F, `dA` toggling) -> `muxOUT` tracks `dB` only and ignores `dA` activity.

Source files
------------

// File: rtl/mux_2_1_pkg.sv
// Shared constants for the 2:1 word multiplexer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Holds the default data word width used by the interface and the mux.
package mux_2_1_pkg;

    // Default data word width in bits; data ports are indexed [w:1].
    localparam int W_DEFAULT = 4;

endpackage : mux_2_1_pkg

// File: rtl/mux_2_1_if.sv
// Bus bundle for the 2:1 word multiplexer (two sources, select, two results).
// Latency: n/a (wiring only).
// Backpressure: none; there is no handshake on this bus.
//
// Signals:
//   dA, dB    [w:1]  data sources (dA chosen when sel = 0, dB when sel = 1)
//   sel              source select
//   muxOUT    [w:1]  combinational result
//   muxOUT_q  [w:1]  result registered on the rising clock edge
// Modports: master drives sources/select, slave (the mux) drives the results.
interface mux_2_1_if
    import mux_2_1_pkg::*;
#(
    parameter int w = W_DEFAULT
);

    logic [w:1] dA;
    logic [w:1] dB;
    logic       sel;
    logic [w:1] muxOUT;
    logic [w:1] muxOUT_q;

    modport master (
        output dA,
        output dB,
        output sel,
        input  muxOUT,
        input  muxOUT_q
    );

    modport slave (
        input  dA,
        input  dB,
        input  sel,
        output muxOUT,
        output muxOUT_q
    );

endinterface : mux_2_1_if

// File: rtl/mux_2_1.sv
// Parameterised-width 2:1 word mux with a combinational and a registered result.
// Latency: muxOUT 0 cycles, muxOUT_q 1 cycle.
// Backpressure: none; every clock edge captures the current selection.
//
// Ports:
//   clk    rising-edge clock for the registered copy only
//   rst_n  asynchronous active-low reset, clears muxOUT_q
//   bus    mux_2_1_if.slave: dA, dB, sel in; muxOUT, muxOUT_q out
// The interface instance must be built with the same w as this module.
module mux_2_1
    import mux_2_1_pkg::*;
#(
    parameter int w = W_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    mux_2_1_if.slave   bus
);

    logic [w:1] sel_dat;
    logic [w:1] q_dat;

    // Plain ternary keeps simulation X-merging when sel is unknown:
    // agreeing bits pass through, differing bits go X.
    assign sel_dat = bus.sel ? bus.dB : bus.dA;

    // Reset release is not synchronised here; the integrator keeps it away
    // from the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_dat <= '0;
        end else begin
            q_dat <= sel_dat;
        end
    end

    assign bus.muxOUT   = sel_dat;
    assign bus.muxOUT_q = q_dat;

endmodule : mux_2_1

// File: tb/tb_mux_2_1.sv
// Self-checking bench for mux_2_1 at w = 4, 1 and 16.
// Expected values are pushed to a scoreboard queue when stimulus is driven
// and popped when the corresponding DUT output is sampled.
module tb_mux_2_1;

    logic clk;
    logic rst_n;

    int n_checks;
    int n_pass;

    logic [31:0] exp_q[$];

    mux_2_1_if #(.w(4))  i4  ();
    mux_2_1_if #(.w(1))  i1  ();
    mux_2_1_if #(.w(16)) i16 ();

    mux_2_1 #(.w(4))  u_dut4  (.clk(clk), .rst_n(rst_n), .bus(i4));
    mux_2_1 #(.w(1))  u_dut1  (.clk(clk), .rst_n(rst_n), .bus(i1));
    mux_2_1 #(.w(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(i16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic push_exp(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    // Pop the oldest expectation and compare; an empty scoreboard is a failure.
    task automatic pop_chk(input string tag, input logic [31:0] got);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL %s: got %h expected <scoreboard empty>", tag, got);
        end else begin
            e = exp_q.pop_front();
            chk(tag, got, e);
        end
    endtask

    // Drive the w=4 mux and check the combinational result one ns later.
    task automatic drive4(input string tag, input logic [3:0] a, input logic [3:0] b, input logic s);
        i4.dA  = a;
        i4.dB  = b;
        i4.sel = s;
        push_exp({28'd0, (s ? b : a)});
        #1;
        pop_chk(tag, {28'd0, i4.muxOUT});
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] pat_a;
        logic [3:0] pat_b;
        n_checks = 0;
        n_pass   = 0;

        rst_n   = 1'b0;
        i4.dA   = 4'h6; i4.dB  = 4'h9;  i4.sel  = 1'b0;
        i1.dA   = 1'b1; i1.dB  = 1'b0;  i1.sel  = 1'b0;
        i16.dA  = 16'hFFFF; i16.dB = 16'h0000; i16.sel = 1'b0;

        // Reset state, plus combinational path valid during reset.
        #2;
        chk("rst_q4",  {28'd0, i4.muxOUT_q}, 32'h0);
        chk("rst_q1",  {31'd0, i1.muxOUT_q}, 32'h0);
        chk("rst_q16", {16'd0, i16.muxOUT_q}, 32'h0);
        chk("rst_comb4", {28'd0, i4.muxOUT}, 32'h6);
        @(posedge clk); #1;
        chk("rst_hold_q4", {28'd0, i4.muxOUT_q}, 32'h0);
        #1 rst_n = 1'b1;

        // sel toggling with dA=0, dB=1.
        drive4("tog0", 4'h0, 4'h1, 1'b0);
        drive4("tog1", 4'h0, 4'h1, 1'b1);
        drive4("tog2", 4'h0, 4'h1, 1'b0);
        drive4("tog3", 4'h0, 4'h1, 1'b1);

        // Alternating bit pattern, each bit checked on its own.
        pat_a = 4'hA;
        pat_b = 4'h5;
        for (int s = 0; s < 2; s++) begin
            i4.dA = pat_a; i4.dB = pat_b; i4.sel = s[0];
            for (int b = 1; b <= 4; b++)
                push_exp({31'd0, (s[0] ? pat_b[b-1] : pat_a[b-1])});
            #1;
            for (int b = 1; b <= 4; b++)
                pop_chk($sformatf("bit%0d_sel%0d", b, s), {31'd0, i4.muxOUT[b]});
        end

        // Registered path: sel changes between edges.
        @(posedge clk); #1;
        i4.dA = 4'h3; i4.dB = 4'hC; i4.sel = 1'b0;
        push_exp(32'h3);
        @(posedge clk); #1;
        pop_chk("reg_cap3", {28'd0, i4.muxOUT_q});
        #2 i4.sel = 1'b1;
        push_exp(32'hC);
        push_exp(32'h3);
        #1;
        pop_chk("reg_comb_c", {28'd0, i4.muxOUT});
        pop_chk("reg_hold3", {28'd0, i4.muxOUT_q});
        push_exp(32'hC);
        @(posedge clk); #1;
        pop_chk("reg_capc", {28'd0, i4.muxOUT_q});

        // Async reset mid-cycle with no clock edge.
        #2 rst_n = 1'b0;
        push_exp(32'h0);
        push_exp(32'hC);
        #1;
        pop_chk("arst_q", {28'd0, i4.muxOUT_q});
        pop_chk("arst_comb", {28'd0, i4.muxOUT});
        @(negedge clk);
        #1 rst_n = 1'b1;
        push_exp(32'h0);
        #1;
        pop_chk("arst_rel_hold", {28'd0, i4.muxOUT_q});
        push_exp(32'hC);
        @(posedge clk); #1;
        pop_chk("arst_resume", {28'd0, i4.muxOUT_q});

        // Width sweep: w=1 and w=16, dA all-ones, dB zero.
        for (int k = 0; k < 3; k++) begin
            logic s;
            s = k[0];
            i1.dA = 1'b1;  i1.dB = 1'b0;  i1.sel = s;
            i16.dA = 16'hFFFF; i16.dB = 16'h0000; i16.sel = s;
            push_exp(s ? 32'h0 : 32'h1);
            push_exp(s ? 32'h0 : 32'hFFFF);
            #1;
            pop_chk($sformatf("w1_comb%0d", k),  {31'd0, i1.muxOUT});
            pop_chk($sformatf("w16_comb%0d", k), {16'd0, i16.muxOUT});
            push_exp(s ? 32'h0 : 32'h1);
            push_exp(s ? 32'h0 : 32'hFFFF);
            @(posedge clk); #1;
            pop_chk($sformatf("w1_q%0d", k),  {31'd0, i1.muxOUT_q});
            pop_chk($sformatf("w16_q%0d", k), {16'd0, i16.muxOUT_q});
        end

        // sel held at 1: dA activity must not reach the output.
        drive4("hold_b0",  4'h0, 4'h0, 1'b1);
        drive4("hold_a_f", 4'hF, 4'h0, 1'b1);
        drive4("hold_bf",  4'hF, 4'hF, 1'b1);
        drive4("hold_a_0", 4'h0, 4'hF, 1'b1);
        drive4("hold_a_7", 4'h7, 4'hF, 1'b1);

        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_left: got %0d entries expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_mux_2_1
